if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF stage: owns the PC, issues one instruction-memory read at a time, returns
//  {pc, instruction, valid} to the IF/ID pipeline register. Honours downstream
//  stall (IF/ID not writing) via a one-entry skid buffer. Honours branch/jump
//  redirect from EX by discarding in-flight/buffered fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_IS    32'h0000_0013  instruction driven on if_is when no valid fetch (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  stall        in   1   1: downstream holds, current output beat not consumed
//  redirect     in   1   1: flush fetch, restart at redirect_pc
//  redirect_pc  in   32  new PC on redirect (low 2 bits ignored, forced 0)
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  read address, stable while imem_req=1 and imem_gnt=0
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data valid (>=1 cycle after gnt, one per gnt)
//  imem_rdata   in   32  read data
//  if_valid     out  1   output beat valid
//  if_pc        out  32  PC of output instruction
//  if_is        out  32  output instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_is=NOP_IS, skid empty.
//  Beat consumed at a rising edge where if_valid=1 and stall=0.
//  Output slot "free" this cycle = (if_valid==0) | (stall==0).
//  States:
//  - FETCH: imem_req=1, imem_addr=pc. On gnt: fpc<=pc, pc<=pc+4 (mod 2^32), ->WAIT.
//           No gnt: stay, request and address held.
//  - WAIT:  imem_req=0. On rvalid: slot free -> if_valid<=1, if_pc<=fpc,
//           if_is<=rdata, ->FETCH; slot not free -> skid<=rdata, ->HOLD.
//  - HOLD:  imem_req=0. When stall=0: output<=skid (pc=fpc), ->FETCH.
//  - DROP:  imem_req=0. Waits for the outstanding rvalid, discards it, ->FETCH.
//  Output not re-loaded and if_valid cleared on consume when nothing new arrives:
//   consumed beat with no load same edge -> if_valid<=0, if_is<=NOP_IS.
//  Redirect (priority below rst, above everything else), at that edge:
//   pc<=redirect_pc&~3; if_valid<=0; if_is<=NOP_IS; skid emptied;
//   next state = DROP if a gnt is outstanding (state WAIT, or FETCH with gnt this
//   cycle), else FETCH. rvalid arriving the same cycle as redirect is discarded.
//  rvalid in FETCH/HOLD is a protocol error: ignored.
//  Latency: req->gnt same cycle min; if_valid rises edge after rvalid. Max
//   throughput one instruction per 2 cycles (single outstanding request).
//  Mid-operation rst: all state to reset values; memory side is reset with the same
//   rst, so no stale rvalid follows.
// TESTING
//  1 rst 2 cyc, gnt=1, rvalid 1 cyc after gnt, rdata=addr|0x13 -> if_pc 0,4,8,
//    if_valid pulses every 2nd cycle, if_is 0x13,0x17,0x1B.
//  2 gnt held 0 for 3 cyc -> imem_req=1, imem_addr=0x0 constant all 3 cycles.
//  3 stall=1 for 4 cyc spanning rvalid of pc 0x8 -> HOLD, no imem_req, if_pc stays 0x4;
//    on release if_pc=0x8 then fetch of 0xC.
//  4 redirect to 0x100 in WAIT for pc 0x8 -> if_valid 0, stale rdata dropped,
//    next imem_addr=0x100, next valid if_pc=0x100.
//  5 redirect to 0x203 same cycle as gnt -> DROP, next imem_addr=0x200.
//  6 rst asserted in HOLD -> next cycle imem_addr=RESET_PC, if_valid=0, if_is=0x13.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight,
// and hands {pc, instruction} to IF/ID through a one-entry skid buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IS   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_is
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] fpc_reg, fpc_next;
    logic [31:0] skid_reg, skid_next;
    logic        valid_reg, valid_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_is_reg, out_is_next;

    logic        slot_free;
    logic        gnt_outstanding;

    assign slot_free = !valid_reg || !stall;

    // A read is still owed to us unless its rvalid lands on this very edge.
    assign gnt_outstanding = ((state_reg == S_FETCH) && imem_gnt)
                          || ((state_reg == S_WAIT) && !imem_rvalid)
                          || ((state_reg == S_DROP) && !imem_rvalid);

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        fpc_next    = fpc_reg;
        skid_next   = skid_reg;
        valid_next  = valid_reg;
        out_pc_next = out_pc_reg;
        out_is_next = out_is_reg;
        imem_req    = (state_reg == S_FETCH);
        imem_addr   = pc_reg;

        // A consumed beat empties the slot unless a new one is loaded below.
        if (valid_reg && !stall) begin
            valid_next  = 1'b0;
            out_is_next = NOP_IS;
        end

        case (state_reg)
            S_FETCH: begin
                if (imem_gnt) begin
                    fpc_next   = pc_reg;
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (slot_free) begin
                        valid_next  = 1'b1;
                        out_pc_next = fpc_reg;
                        out_is_next = imem_rdata;
                        state_next  = S_FETCH;
                    end else begin
                        skid_next  = imem_rdata;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    valid_next  = 1'b1;
                    out_pc_next = fpc_reg;
                    out_is_next = skid_reg;
                    state_next  = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase

        if (redirect) begin
            pc_next     = {redirect_pc[31:2], 2'b00};
            valid_next  = 1'b0;
            out_is_next = NOP_IS;
            skid_next   = NOP_IS;
            state_next  = gnt_outstanding ? S_DROP : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_FETCH;
            pc_reg     <= RESET_PC;
            fpc_reg    <= RESET_PC;
            skid_reg   <= NOP_IS;
            valid_reg  <= 1'b0;
            out_pc_reg <= 32'h0000_0000;
            out_is_reg <= NOP_IS;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            fpc_reg    <= fpc_next;
            skid_reg   <= skid_next;
            valid_reg  <= valid_next;
            out_pc_reg <= out_pc_next;
            out_is_reg <= out_is_next;
        end
    end

    assign if_valid = valid_reg;
    assign if_pc    = out_pc_reg;
    assign if_is    = out_is_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a memory responder and program-order
// scoreboard drive the stimulus, a negedge monitor checks every delivered beat.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IS   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_is;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_IS   (NOP_IS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_is       (if_is)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    int          compared   = 0;
    int          mismatched = 0;
    int          beats      = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: values seen at negedge are the ones the next rising edge samples.
    initial begin
        logic        prev_req, prev_gnt, prev_redir, prev_rst;
        logic [31:0] prev_addr, exp_pc;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_rst = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("rst_valid", {31'b0, if_valid}, 32'd0);
                check("rst_pc", if_pc, 32'h0);
                check("rst_is", if_is, NOP_IS);
                check("rst_req", {31'b0, imem_req}, 32'd1);
                check("rst_addr", imem_addr, RESET_PC);
            end else begin
                if (prev_redir)
                    check("redirect_valid", {31'b0, if_valid}, 32'd0);
                if (prev_req && !prev_gnt && !prev_redir) begin
                    check("held_req", {31'b0, imem_req}, 32'd1);
                    check("held_addr", imem_addr, prev_addr);
                end
            end
            if (imem_req)
                check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (!if_valid)
                check("idle_is", if_is, NOP_IS);
            if (if_valid && !stall) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", if_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("beat_pc", if_pc, exp_pc);
                    check("beat_is", if_is, mem_word(exp_pc));
                end
            end
            prev_req   = imem_req;
            prev_gnt   = imem_gnt;
            prev_addr  = imem_addr;
            prev_redir = redirect;
            prev_rst   = rst;
        end
    end

    // Stimulus: memory responder, stall/redirect/reset generator, expected PC stream.
    initial begin
        logic        pending;
        logic [31:0] pend_addr, req_addr;
        int unsigned delay;
        bit          directed;
        pending = 1'b0; pend_addr = 32'h0; req_addr = 32'h0; delay = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            // Apply what the edge just passed did to the program-order stream.
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                pending = 1'b0;
            end else begin
                if (redirect) begin
                    exp_q.delete();
                    exp_q.push_back(redirect_pc & ~32'd3);
                end
                if (imem_rvalid) pending = 1'b0;
                if (imem_gnt) begin
                    pending   = 1'b1;
                    pend_addr = req_addr;
                    delay     = directed ? 0 : $urandom_range(0, 3);
                end
            end
            while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);

            directed = (cyc < 42);
            if (cyc == 41) check("directed_beats_ge18", (beats >= 18) ? 32'd1 : 32'd0, 32'd1);

            rst = (cyc < 2) || (!directed && $urandom_range(0, 199) == 0);
            if (pending && !rst)
                check("single_outstanding", {31'b0, imem_req}, 32'd0);

            imem_gnt = imem_req && !rst && (directed || $urandom_range(0, 3) != 0);
            req_addr = imem_addr;

            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending && !rst) begin
                if (delay == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                end else begin
                    delay--;
                end
            end

            stall       = !directed && ($urandom_range(0, 2) == 0);
            redirect    = !directed && !rst && ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF5 : $urandom;
        end

        @(posedge clk);
        #1;
        check("liveness_beats_ge200", (beats >= 200) ? 32'd1 : 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
